// File: rtl/free_list_banked_pkg.sv
// Shared constants, index types and reset-content helper for the banked PR free list.
// Used by free_list_bank and free_list_banked.
package free_list_banked_pkg;

  localparam int PR_COUNT                  = 128;
  localparam int FREE_LIST_BANK_COUNT      = 4;
  localparam int ENQ_PORTS                 = 2;
  localparam int INIT_FREE_START           = 32;
  localparam int LOWER_THRESHOLD           = 8;
  localparam int UPPER_THRESHOLD           = 24;
  localparam int FREE_LIST_LENGTH_PER_BANK = PR_COUNT / FREE_LIST_BANK_COUNT;

  localparam int BANK_COUNT    = FREE_LIST_BANK_COUNT;
  localparam int DEPTH         = FREE_LIST_LENGTH_PER_BANK;
  localparam int PR_W          = $clog2(PR_COUNT);
  localparam int BANK_W        = $clog2(BANK_COUNT);
  localparam int PTR_W         = $clog2(DEPTH);
  localparam int CNT_W         = PTR_W + 1;
  localparam int INIT_PER_BANK = INIT_FREE_START / BANK_COUNT;
  localparam int INIT_COUNT    = DEPTH - INIT_PER_BANK;

  typedef logic [PR_W-1:0]  pr_t;
  typedef logic [PTR_W-1:0] ptr_t;
  typedef logic [CNT_W-1:0] cnt_t;

  // Bank b, slot i holds PR {i + INIT_PER_BANK, b} after reset.
  function automatic pr_t init_pr(input int bank, input int idx);
    return pr_t'((idx + INIT_PER_BANK) * BANK_COUNT + bank);
  endfunction

endpackage

// File: rtl/free_list_bank.sv
// One bank of the free list: circular FIFO with multi-port enqueue, single dequeue,
// occupancy count and hysteresis low flag. FREE_LIST_DOUBLE_FREE_CHECK_EN exports accept/overflow.
module free_list_bank
  import free_list_banked_pkg::*;
#(
  parameter int BANK_ID = 0
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [ENQ_PORTS-1:0] enq_valid,
  input  pr_t  [ENQ_PORTS-1:0] enq_pr,
  input  logic                 deq_ready,
  output logic                 deq_valid,
  output pr_t                  deq_pr,
  output cnt_t                 count,
  output logic                 bank_low
`ifdef FREE_LIST_DOUBLE_FREE_CHECK_EN
  ,
  output logic [ENQ_PORTS-1:0] enq_accept,
  output logic                 overflow
`endif
);

  pr_t                  mem_r [DEPTH];
  ptr_t                 head_r;
  ptr_t                 tail_r;
  cnt_t                 count_r;
  logic                 low_r;

  logic                 deq_fire_s;
  cnt_t                 room_s;
  cnt_t                 n_acc_s;
  cnt_t                 count_next_s;
  logic [ENQ_PORTS-1:0] accept_s;
  ptr_t [ENQ_PORTS-1:0] wr_idx_s;

  assign deq_valid  = (count_r != cnt_t'(0));
  assign deq_pr     = mem_r[head_r];
  assign count      = count_r;
  assign bank_low   = low_r;
  assign deq_fire_s = deq_valid & deq_ready;

`ifdef FREE_LIST_DOUBLE_FREE_CHECK_EN
  assign enq_accept = accept_s;
  assign overflow   = |(enq_valid & ~accept_s);
`endif

  // Pack valid enqueues in port order at tail, dropping those beyond the free room.
  always_comb begin
    room_s   = cnt_t'(DEPTH) - count_r + cnt_t'(deq_fire_s);
    n_acc_s  = cnt_t'(0);
    accept_s = '0;
    wr_idx_s = '0;
    for (int p = 0; p < ENQ_PORTS; p++) begin
      if (enq_valid[p] && (n_acc_s < room_s)) begin
        accept_s[p] = 1'b1;
        wr_idx_s[p] = tail_r + ptr_t'(n_acc_s);
        n_acc_s     = n_acc_s + cnt_t'(1);
      end else begin
        accept_s[p] = 1'b0;
      end
    end
    count_next_s = count_r + n_acc_s - cnt_t'(deq_fire_s);
  end

  // FIFO storage, pointers, count and hysteresis flag.
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= (i < INIT_COUNT) ? init_pr(BANK_ID, i) : pr_t'(0);
      end
      head_r  <= ptr_t'(0);
      tail_r  <= ptr_t'(INIT_COUNT);
      count_r <= cnt_t'(INIT_COUNT);
      low_r   <= (INIT_COUNT < LOWER_THRESHOLD);
    end else begin
      for (int p = 0; p < ENQ_PORTS; p++) begin
        if (accept_s[p]) begin
          mem_r[wr_idx_s[p]] <= enq_pr[p];
        end
      end
      head_r  <= head_r + ptr_t'(deq_fire_s);
      tail_r  <= tail_r + ptr_t'(n_acc_s);
      count_r <= count_next_s;
      if (count_next_s < cnt_t'(LOWER_THRESHOLD)) begin
        low_r <= 1'b1;
      end else if (count_next_s > cnt_t'(UPPER_THRESHOLD)) begin
        low_r <= 1'b0;
      end else begin
        low_r <= low_r;
      end
    end
  end

endmodule

// File: rtl/free_list_banked.sv
// Banked PR free list top: routes enqueue ports to banks by PR low bits.
// FREE_LIST_DOUBLE_FREE_CHECK_EN adds the is-free vector and sticky double_free_err.
module free_list_banked
  import free_list_banked_pkg::*;
(
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [ENQ_PORTS-1:0]  enq_valid_by_port,
  input  pr_t  [ENQ_PORTS-1:0]  enq_PR_by_port,
  output logic [BANK_COUNT-1:0] deq_valid_by_bank,
  output pr_t  [BANK_COUNT-1:0] deq_PR_by_bank,
  input  logic [BANK_COUNT-1:0] deq_ready_by_bank,
  output logic [BANK_COUNT-1:0] bank_low_by_bank,
  output cnt_t [BANK_COUNT-1:0] count_by_bank
`ifdef FREE_LIST_DOUBLE_FREE_CHECK_EN
  ,
  output logic                  double_free_err
`endif
);

  logic [BANK_COUNT-1:0][ENQ_PORTS-1:0] bank_enq_valid_s;

  // Steer each valid port to the bank selected by its PR low bits.
  always_comb begin
    bank_enq_valid_s = '0;
    for (int b = 0; b < BANK_COUNT; b++) begin
      for (int p = 0; p < ENQ_PORTS; p++) begin
        bank_enq_valid_s[b][p] = enq_valid_by_port[p] &&
                                 (enq_PR_by_port[p][BANK_W-1:0] == BANK_W'(b));
      end
    end
  end

`ifdef FREE_LIST_DOUBLE_FREE_CHECK_EN
  logic [BANK_COUNT-1:0][ENQ_PORTS-1:0] bank_accept_s;
  logic [BANK_COUNT-1:0]                bank_overflow_s;
`endif

  for (genvar b = 0; b < BANK_COUNT; b++) begin : g_bank
    free_list_bank #(
      .BANK_ID (b)
    ) u_bank (
      .CLK        (CLK),
      .RST        (RST),
      .enq_valid  (bank_enq_valid_s[b]),
      .enq_pr     (enq_PR_by_port),
      .deq_ready  (deq_ready_by_bank[b]),
      .deq_valid  (deq_valid_by_bank[b]),
      .deq_pr     (deq_PR_by_bank[b]),
      .count      (count_by_bank[b]),
      .bank_low   (bank_low_by_bank[b])
`ifdef FREE_LIST_DOUBLE_FREE_CHECK_EN
      ,
      .enq_accept (bank_accept_s[b]),
      .overflow   (bank_overflow_s[b])
`endif
    );
  end

`ifdef FREE_LIST_DOUBLE_FREE_CHECK_EN
  logic [PR_COUNT-1:0]  is_free_r;
  logic [PR_COUNT-1:0]  free_next_s;
  logic                 err_r;
  logic                 err_next_s;
  logic [ENQ_PORTS-1:0] port_accept_s;

  assign double_free_err = err_r;

  // Dequeues clear first, then ports in order; re-freeing a marked PR or a drop flags the error.
  always_comb begin
    port_accept_s = '0;
    for (int b = 0; b < BANK_COUNT; b++) begin
      port_accept_s = port_accept_s | bank_accept_s[b];
    end
    free_next_s = is_free_r;
    err_next_s  = err_r | (|bank_overflow_s);
    for (int b = 0; b < BANK_COUNT; b++) begin
      free_next_s[deq_PR_by_bank[b]] = free_next_s[deq_PR_by_bank[b]] &
                                       ~(deq_valid_by_bank[b] & deq_ready_by_bank[b]);
    end
    for (int p = 0; p < ENQ_PORTS; p++) begin
      err_next_s = err_next_s | (enq_valid_by_port[p] & free_next_s[enq_PR_by_port[p]]);
      free_next_s[enq_PR_by_port[p]] = free_next_s[enq_PR_by_port[p]] | port_accept_s[p];
    end
  end

  // Is-free vector and sticky error flag.
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < PR_COUNT; i++) begin
        is_free_r[i] <= (i >= INIT_FREE_START);
      end
      err_r <= 1'b0;
    end else begin
      is_free_r <= free_next_s;
      err_r     <= err_next_s;
    end
  end
`endif

endmodule

// File: tb/tb_free_list_banked.sv
// Randomized scoreboard bench for free_list_banked against a queue-based reference model.
module tb_free_list_banked;
  import free_list_banked_pkg::*;

  logic                  CLK = 1'b0;
  logic                  RST;
  logic [ENQ_PORTS-1:0]  enq_valid_by_port;
  pr_t  [ENQ_PORTS-1:0]  enq_PR_by_port;
  logic [BANK_COUNT-1:0] deq_valid_by_bank;
  pr_t  [BANK_COUNT-1:0] deq_PR_by_bank;
  logic [BANK_COUNT-1:0] deq_ready_by_bank;
  logic [BANK_COUNT-1:0] bank_low_by_bank;
  cnt_t [BANK_COUNT-1:0] count_by_bank;
`ifdef FREE_LIST_DOUBLE_FREE_CHECK_EN
  logic                  double_free_err;
`endif

  free_list_banked dut (
    .CLK               (CLK),
    .RST               (RST),
    .enq_valid_by_port (enq_valid_by_port),
    .enq_PR_by_port    (enq_PR_by_port),
    .deq_valid_by_bank (deq_valid_by_bank),
    .deq_PR_by_bank    (deq_PR_by_bank),
    .deq_ready_by_bank (deq_ready_by_bank),
    .bank_low_by_bank  (bank_low_by_bank),
    .count_by_bank     (count_by_bank)
`ifdef FREE_LIST_DOUBLE_FREE_CHECK_EN
    ,
    .double_free_err   (double_free_err)
`endif
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    cnt_t [BANK_COUNT-1:0] cnt;
    logic [BANK_COUNT-1:0] valid;
    logic [BANK_COUNT-1:0] low;
    pr_t  [BANK_COUNT-1:0] head;
    logic                  err;
  } snap_t;

  int    checks = 0;
  int    errors = 0;
  snap_t exp_state_q[$];
  int    exp_pr_q[BANK_COUNT][$];
  int    model_q[BANK_COUNT][$];
  bit    model_low[BANK_COUNT];
  bit    model_free[PR_COUNT];
  bit    model_err;
  int    pool[$];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic void model_reset();
    for (int b = 0; b < BANK_COUNT; b++) begin
      model_q[b].delete();
      for (int i = INIT_FREE_START / BANK_COUNT; i < PR_COUNT / BANK_COUNT; i++) begin
        model_q[b].push_back(i * BANK_COUNT + b);
      end
      model_low[b] = (model_q[b].size() < LOWER_THRESHOLD);
    end
    for (int i = 0; i < PR_COUNT; i++) model_free[i] = (i >= INIT_FREE_START);
    model_err = 1'b0;
    pool.delete();
  endfunction

  // Called at posedge+1: records expected visible state, applies inputs, advances the model.
  task automatic do_cycle(input bit rst, input logic [BANK_COUNT-1:0] rdy,
                          input logic [ENQ_PORTS-1:0] ev, input pr_t [ENQ_PORTS-1:0] epr);
    snap_t s;
    for (int b = 0; b < BANK_COUNT; b++) begin
      s.cnt[b]   = cnt_t'(model_q[b].size());
      s.valid[b] = (model_q[b].size() > 0);
      s.low[b]   = model_low[b];
      s.head[b]  = (model_q[b].size() > 0) ? pr_t'(model_q[b][0]) : pr_t'(0);
    end
    s.err = model_err;
    exp_state_q.push_back(s);
    RST = rst;
    deq_ready_by_bank = rdy;
    enq_valid_by_port = ev;
    enq_PR_by_port    = epr;
    if (rst) begin
      model_reset();
    end else begin
      for (int b = 0; b < BANK_COUNT; b++) begin
        if (rdy[b] && model_q[b].size() > 0) begin
          int pr = model_q[b].pop_front();
          exp_pr_q[b].push_back(pr);
          model_free[pr] = 1'b0;
          pool.push_back(pr);
        end
      end
      for (int p = 0; p < ENQ_PORTS; p++) begin
        if (ev[p]) begin
          int pr = int'(epr[p]);
          int b  = pr % BANK_COUNT;
          if (model_free[pr]) model_err = 1'b1;
          if (model_q[b].size() < PR_COUNT / BANK_COUNT) begin
            model_q[b].push_back(pr);
            model_free[pr] = 1'b1;
          end else begin
            model_err = 1'b1;
          end
        end
      end
      for (int b = 0; b < BANK_COUNT; b++) begin
        if (model_q[b].size() < LOWER_THRESHOLD) model_low[b] = 1'b1;
        else if (model_q[b].size() > UPPER_THRESHOLD) model_low[b] = 1'b0;
      end
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic random_cycle(input bit rst);
    logic [BANK_COUNT-1:0] rdy;
    logic [ENQ_PORTS-1:0]  ev;
    pr_t  [ENQ_PORTS-1:0]  epr;
    rdy = BANK_COUNT'($urandom_range(0, (1 << BANK_COUNT) - 1));
    ev  = '0;
    epr = '0;
    for (int p = 0; p < ENQ_PORTS; p++) begin
      if (pool.size() > 0 && $urandom_range(0, 1) == 1) begin
        int idx = $urandom_range(0, pool.size() - 1);
        epr[p] = pr_t'(pool[idx]);
        ev[p]  = 1'b1;
        pool.delete(idx);
      end
    end
    do_cycle(rst, rdy, ev, epr);
  endtask

  // Monitor: compares visible state every cycle and pops expected PRs on each transfer.
  always @(negedge CLK) begin
    snap_t s;
    if (exp_state_q.size() > 0) begin
      s = exp_state_q.pop_front();
      for (int b = 0; b < BANK_COUNT; b++) begin
        check($sformatf("count[%0d]", b), int'(count_by_bank[b]), int'(s.cnt[b]));
        check($sformatf("deq_valid[%0d]", b), int'(deq_valid_by_bank[b]), int'(s.valid[b]));
        check($sformatf("bank_low[%0d]", b), int'(bank_low_by_bank[b]), int'(s.low[b]));
        if (s.valid[b]) check($sformatf("head[%0d]", b), int'(deq_PR_by_bank[b]), int'(s.head[b]));
      end
`ifdef FREE_LIST_DOUBLE_FREE_CHECK_EN
      check("double_free_err", int'(double_free_err), int'(s.err));
`endif
      for (int b = 0; b < BANK_COUNT; b++) begin
        if (!RST && deq_valid_by_bank[b] && deq_ready_by_bank[b]) begin
          if (exp_pr_q[b].size() == 0) begin
            checks++;
            errors++;
            $display("FAIL deq_pr[%0d]: unexpected transfer of PR %0d, none expected", b, deq_PR_by_bank[b]);
          end else begin
            check($sformatf("deq_pr[%0d]", b), int'(deq_PR_by_bank[b]), exp_pr_q[b].pop_front());
          end
        end
      end
    end
  end

  initial begin
    int left;
    RST = 1'b1;
    deq_ready_by_bank = '0;
    enq_valid_by_port = '0;
    enq_PR_by_port    = '0;
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b0;
    model_reset();

    do_cycle(1'b0, 4'b0000, 2'b00, {7'd0, 7'd0});
    repeat (17) do_cycle(1'b0, 4'b0010, 2'b00, {7'd0, 7'd0});
    do_cycle(1'b0, 4'b0010, 2'b11, {7'd9, 7'd5});
    repeat (2) do_cycle(1'b0, 4'b0000, 2'b00, {7'd0, 7'd0});

    while (model_q[2].size() > 0) do_cycle(1'b0, 4'b0100, 2'b00, {7'd0, 7'd0});
    do_cycle(1'b0, 4'b0100, 2'b01, {7'd0, 7'd6});
    do_cycle(1'b0, 4'b0100, 2'b00, {7'd0, 7'd0});
    do_cycle(1'b0, 4'b0000, 2'b00, {7'd0, 7'd0});

    for (int k = 0; k < 4; k++) begin
      do_cycle(1'b0, 4'b0000, 2'b11, {pr_t'(7 + 8 * k), pr_t'(3 + 8 * k)});
    end
    do_cycle(1'b0, 4'b0000, 2'b01, {7'd0, 7'd3});
    repeat (2) do_cycle(1'b0, 4'b0000, 2'b00, {7'd0, 7'd0});

    repeat (300) random_cycle(1'b0);
    random_cycle(1'b1);
    do_cycle(1'b0, 4'b0000, 2'b00, {7'd0, 7'd0});
    repeat (200) random_cycle(1'b0);
    repeat (2) do_cycle(1'b0, 4'b0000, 2'b00, {7'd0, 7'd0});

    left = exp_state_q.size();
    for (int b = 0; b < BANK_COUNT; b++) left += exp_pr_q[b].size();
    check("scoreboard_drained", left, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
